// File: rtl/updown_counter_param_if.sv
// Bus bundle for updown_counter_param.
//   master : drives the controls (en, up_down, load, load_val, clr_flags) and
//            observes the counter state.
//   slave  : the counter itself; consumes the controls and drives
//            count, at_zero, at_max, bnd_p, ovf, unf, halted.
// Clock and reset are not part of the bundle; they stay plain module ports.
interface updown_counter_param_if #(
   parameter int unsigned WIDTH = 8
);
   logic             en;
   logic             up_down;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic             clr_flags;
   logic [WIDTH-1:0] count;
   logic             at_zero;
   logic             at_max;
   logic             bnd_p;
   logic             ovf;
   logic             unf;
   logic             halted;

   modport master (
      output en, up_down, load, load_val, clr_flags,
      input  count, at_zero, at_max, bnd_p, ovf, unf, halted
   );

   modport slave (
      input  en, up_down, load, load_val, clr_flags,
      output count, at_zero, at_max, bnd_p, ovf, unf, halted
   );
endinterface

// File: rtl/updown_counter_param.sv
// Parametrised synchronous up/down counter with parallel load, count enable and
// modulo limit MAX_VAL. Boundary behaviour chosen by MODE: 0 wrap, 1 saturate,
// 2 one-shot (stops and raises halted until the next load or reset).
// Ports:
//   clk    : clock, all state changes on the rising edge
//   reset  : synchronous active-high reset, overrides every other input
//   bus    : slave side of updown_counter_param_if
//            in : en, up_down (1 = up), load, load_val, clr_flags
//            out: count, at_zero, at_max, bnd_p (registered boundary pulse),
//                 ovf/unf (sticky), halted (one-shot only)
module updown_counter_param #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned MAX_VAL = (2 ** WIDTH) - 1,
   parameter int unsigned MODE    = 0
) (
   input logic                    clk,
   input logic                    reset,
   updown_counter_param_if.slave  bus
);

   localparam int unsigned ModeWrap    = 0;
   localparam int unsigned ModeSat     = 1;
   localparam int unsigned ModeOneshot = 2;

   localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] Zero   = '0;
   localparam logic [WIDTH-1:0] One    = WIDTH'(1);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic             bnd_q, bnd_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StRun;
         count_q <= '0;
         bnd_q   <= 1'b0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         bnd_q   <= bnd_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      bnd_d   = 1'b0;
      // Clear first; a set event below overrides, so a simultaneous set wins.
      ovf_d   = ovf_q & ~bus.clr_flags;
      unf_d   = unf_q & ~bus.clr_flags;

      if (bus.load) begin
         count_d = (bus.load_val > MaxVal) ? MaxVal : bus.load_val;
         state_d = StRun;
      end else if (bus.en && (state_q == StRun)) begin
         if (bus.up_down) begin
            if (count_q == MaxVal) begin
               bnd_d = 1'b1;
               ovf_d = 1'b1;
               if (MODE == ModeWrap) begin
                  count_d = Zero;
               end else if (MODE == ModeOneshot) begin
                  state_d = StHalt;
               end
            end else begin
               count_d = count_q + One;
            end
         end else begin
            if (count_q == Zero) begin
               bnd_d = 1'b1;
               unf_d = 1'b1;
               if (MODE == ModeWrap) begin
                  count_d = MaxVal;
               end else if (MODE == ModeOneshot) begin
                  state_d = StHalt;
               end
            end else begin
               count_d = count_q - One;
            end
         end
      end
   end

   // Saturate and wrap never leave StRun; keep the output tied low for them.
   localparam bit HaltAllowed = (MODE != ModeWrap) && (MODE != ModeSat);

   assign bus.count   = count_q;
   assign bus.at_zero = (count_q == Zero);
   assign bus.at_max  = (count_q == MaxVal);
   assign bus.bnd_p   = bnd_q;
   assign bus.ovf     = ovf_q;
   assign bus.unf     = unf_q;
   assign bus.halted  = HaltAllowed && (state_q == StHalt);

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param. Five instances share the same
// stimulus: 0 = wrap/255, 1 = wrap/9, 2 = saturate/9, 3 = one-shot/9,
// 4 = wrap/99. Expectations are queued before each edge and checked after it.
module tb_updown_counter_param;

   logic       clk;
   logic       reset;
   logic       en;
   logic       up_down;
   logic       load;
   logic [7:0] load_val;
   logic       clr_flags;

   logic [7:0] o_count [5];
   logic       o_zero  [5];
   logic       o_max   [5];
   logic       o_bnd   [5];
   logic       o_ovf   [5];
   logic       o_unf   [5];
   logic       o_halt  [5];

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      int         id;
      logic [7:0] count;
      logic       bnd;
      logic       ovf;
      logic       unf;
      logic       halt;
   } exp_t;

   exp_t sb[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      updown_counter_param_if #(.WIDTH(8)) bus ();

      assign bus.en        = en;
      assign bus.up_down   = up_down;
      assign bus.load      = load;
      assign bus.load_val  = load_val;
      assign bus.clr_flags = clr_flags;

      updown_counter_param #(
         .WIDTH   (8),
         .MAX_VAL ((g == 0) ? 255 : ((g == 4) ? 99 : 9)),
         .MODE    ((g == 2) ? 1 : ((g == 3) ? 2 : 0))
      ) u_dut (
         .clk   (clk),
         .reset (reset),
         .bus   (bus)
      );

      assign o_count[g] = bus.count;
      assign o_zero[g]  = bus.at_zero;
      assign o_max[g]   = bus.at_max;
      assign o_bnd[g]   = bus.bnd_p;
      assign o_ovf[g]   = bus.ovf;
      assign o_unf[g]   = bus.unf;
      assign o_halt[g]  = bus.halted;
   end

   function automatic logic [7:0] max_of(input int id);
      return (id == 0) ? 8'd255 : ((id == 4) ? 8'd99 : 8'd9);
   endfunction

   task automatic chk(input string tag, input string fld, input logic [7:0] obs,
                      input logic [7:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s.%s: got %0d expected %0d", tag, fld, obs, expv);
      end
   endtask

   task automatic expect_st(input string tag, input int id, input logic [7:0] c,
                            input logic b, input logic o, input logic u,
                            input logic h);
      exp_t e;
      e.tag = tag; e.id = id; e.count = c; e.bnd = b; e.ovf = o; e.unf = u; e.halt = h;
      sb.push_back(e);
   endtask

   // One rising edge, then check every queued expectation.
   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, "count", o_count[e.id], e.count);
         chk(e.tag, "at_zero", {7'd0, o_zero[e.id]}, {7'd0, e.count == 8'd0});
         chk(e.tag, "at_max", {7'd0, o_max[e.id]}, {7'd0, e.count == max_of(e.id)});
         chk(e.tag, "bnd_p", {7'd0, o_bnd[e.id]}, {7'd0, e.bnd});
         chk(e.tag, "ovf", {7'd0, o_ovf[e.id]}, {7'd0, e.ovf});
         chk(e.tag, "unf", {7'd0, o_unf[e.id]}, {7'd0, e.unf});
         chk(e.tag, "halted", {7'd0, o_halt[e.id]}, {7'd0, e.halt});
      end
   endtask

   task automatic do_reset();
      reset = 1'b1; en = 1'b0; load = 1'b0; clr_flags = 1'b0; up_down = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; en = 1'b1; up_down = 1'b1; load = 1'b0;
      load_val = 8'd0; clr_flags = 1'b0;

      // Reset state on every instance, even with en high.
      for (int i = 0; i < 5; i++) expect_st("reset", i, 8'd0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;

      // T1: wrap/255 counts up through 255 back to 0.
      en = 1'b1; up_down = 1'b1;
      for (int k = 1; k <= 256; k++) begin
         expect_st("t1_up", 0, 8'(k % 256), k == 256, k == 256, 0, 0);
         tick();
      end
      en = 1'b0;
      expect_st("t1_idle", 0, 8'd0, 0, 1, 0, 0);
      tick();

      // T2: wrap/9 load 3 then count down past zero.
      do_reset();
      load = 1'b1; load_val = 8'd3;
      expect_st("t2_load", 1, 8'd3, 0, 0, 0, 0);
      tick();
      load = 1'b0; en = 1'b1; up_down = 1'b0;
      expect_st("t2_dn1", 1, 8'd2, 0, 0, 0, 0); tick();
      expect_st("t2_dn2", 1, 8'd1, 0, 0, 0, 0); tick();
      expect_st("t2_dn3", 1, 8'd0, 0, 0, 0, 0); tick();
      expect_st("t2_dn4", 1, 8'd9, 1, 0, 1, 0); tick();
      en = 1'b0;
      expect_st("t2_hold", 1, 8'd9, 0, 0, 1, 0); tick();

      // T3: saturate/9 load 8, up 3, down 1.
      do_reset();
      load = 1'b1; load_val = 8'd8;
      expect_st("t3_load", 2, 8'd8, 0, 0, 0, 0); tick();
      load = 1'b0; en = 1'b1; up_down = 1'b1;
      expect_st("t3_up1", 2, 8'd9, 0, 0, 0, 0); tick();
      expect_st("t3_up2", 2, 8'd9, 1, 1, 0, 0); tick();
      expect_st("t3_up3", 2, 8'd9, 1, 1, 0, 0); tick();
      up_down = 1'b0;
      expect_st("t3_dn", 2, 8'd8, 0, 1, 0, 0); tick();

      // T4: one-shot/9 load 1, down 3, then reload 5 with en still high.
      do_reset();
      load = 1'b1; load_val = 8'd1;
      expect_st("t4_load", 3, 8'd1, 0, 0, 0, 0); tick();
      load = 1'b0; en = 1'b1; up_down = 1'b0;
      expect_st("t4_dn1", 3, 8'd0, 0, 0, 0, 0); tick();
      expect_st("t4_dn2", 3, 8'd0, 1, 0, 1, 1); tick();
      expect_st("t4_dn3", 3, 8'd0, 0, 0, 1, 1); tick();
      up_down = 1'b1;
      expect_st("t4_haltup", 3, 8'd0, 0, 0, 1, 1); tick();
      load = 1'b1; load_val = 8'd5;
      expect_st("t4_reload", 3, 8'd5, 0, 0, 1, 0); tick();
      load = 1'b0;
      expect_st("t4_run", 3, 8'd6, 0, 0, 1, 0); tick();
      // Reset while halted: drive back to halt, then reset.
      load = 1'b1; load_val = 8'd9; tick();
      load = 1'b0;
      expect_st("t4_halt2", 3, 8'd9, 1, 1, 1, 1); tick();
      reset = 1'b1;
      expect_st("t4_rst_halt", 3, 8'd0, 0, 0, 0, 0); tick();
      reset = 1'b0;

      // T5: wrap/99 load wins over en and is clamped.
      do_reset();
      load = 1'b1; en = 1'b1; up_down = 1'b1; load_val = 8'd200;
      expect_st("t5_clamp", 4, 8'd99, 0, 0, 0, 0); tick();
      load_val = 8'd7;
      expect_st("t5_load7", 4, 8'd7, 0, 0, 0, 0); tick();

      // T6: set beats clear, then clear alone, then reset mid-count.
      load_val = 8'd99;
      expect_st("t6_load99", 4, 8'd99, 0, 0, 0, 0); tick();
      load = 1'b0; clr_flags = 1'b1;
      expect_st("t6_set_clr", 4, 8'd0, 1, 1, 0, 0); tick();
      en = 1'b0;
      expect_st("t6_clr", 4, 8'd0, 0, 0, 0, 0); tick();
      clr_flags = 1'b0; en = 1'b1; up_down = 1'b0;
      expect_st("t6_under", 4, 8'd99, 1, 0, 1, 0); tick();
      expect_st("t6_dn", 4, 8'd98, 0, 0, 1, 0); tick();
      reset = 1'b1;
      for (int i = 0; i < 5; i++) expect_st("t6_reset", i, 8'd0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
